fsync_node: RTL and testbench

Parametrised Fractal Sync tree node for the MAGIA mesh, replacing the fixed single-barrier, square-mesh-only sync tree. Each node merges barrier requests from two children (tiles or lower nodes). It either terminates a barrier locally or forwards one merged request to its parent, then fans the response back down. It supports `N_IDS` concurrent barrier IDs, arbitrary power-of-two `N_TILES_X`/`N_TILES_Y` through the level parameters, and error reporting.

---
 rtl/magia_pkg.sv | 28 ++
 rtl/fsync_node_entry.sv | 142 ++++++++++++++
 rtl/fsync_node.sv | 151 +++++++++++++++
 tb/tb_fsync_node.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/magia_pkg.sv
// Mesh-wide constants and types shared by the fractal sync tree.
package magia_pkg;

  localparam int unsigned N_TILES_X = 4;
  localparam int unsigned N_TILES_Y = 4;

  // Number of tree levels above the tiles. The sum of the per-axis depths
  // keeps this valid for non-square power-of-two meshes.
  localparam int unsigned FSYNC_LVL = $clog2(N_TILES_X) + $clog2(N_TILES_Y);

  // Level field must be able to encode every level up to FSYNC_LVL.
  localparam int unsigned TILE_FSYNC_W = (FSYNC_LVL < 1) ? 1 : $clog2(FSYNC_LVL + 1);

  localparam int unsigned FSYNC_N_IDS = 4;
  localparam int unsigned FSYNC_ID_W  = (FSYNC_N_IDS > 1) ? $clog2(FSYNC_N_IDS) : 1;

  typedef logic [TILE_FSYNC_W-1:0] fsync_lvl_t;
  typedef logic [FSYNC_ID_W-1:0]   fsync_id_t;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_WAIT,
    FS_FWD,
    FS_UP_WAIT,
    FS_REL
  } fsync_state_e;

endpackage

// File: rtl/fsync_node_entry.sv
// Per-barrier-ID state machine of a sync tree node: pairs the two child
// arrivals, decides local release vs. forwarding, tracks pending releases.
module fsync_id_entry
  import magia_pkg::*;
#(
  parameter int unsigned LVL_W    = TILE_FSYNC_W,
  parameter int unsigned NODE_LVL = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            acc_i,
  input  logic [1:0][LVL_W-1:0] lvl_i,
  input  logic                  up_gnt_i,
  input  logic                  up_rsp_i,
  input  logic [1:0]            rsp_hs_i,
  output logic [1:0]            arrived_o,
  output logic                  busy_o,
  output logic                  fwd_o,
  output logic [1:0]            pend_o,
  output logic [LVL_W-1:0]      lvl_o,
  output logic                  err_o
);

  localparam logic [LVL_W-1:0] NODE_LVL_C = LVL_W'(NODE_LVL);

  fsync_state_e     state_q, state_d;
  logic [1:0]       arrived_q, arrived_d;
  logic [1:0]       pend_q, pend_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;

  logic [1:0]       ok;
  logic             done;
  logic [LVL_W-1:0] dlvl;
  logic [LVL_W-1:0] cmp;

  // Next-state: arrival pairing, forwarding handshake, release bookkeeping.
  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    pend_d    = pend_q;
    lvl_d     = lvl_q;
    err_o     = 1'b0;
    done      = 1'b0;
    dlvl      = lvl_q;
    cmp       = '0;
    // A request below this node's level can never be served here.
    ok[0] = acc_i[0] && (lvl_i[0] >= NODE_LVL_C);
    ok[1] = acc_i[1] && (lvl_i[1] >= NODE_LVL_C);
    if ((acc_i & ~ok) != 2'b00) err_o = 1'b1;

    unique case (state_q)
      FS_IDLE: begin
        if (ok == 2'b11) begin
          if (lvl_i[0] != lvl_i[1]) begin
            err_o = 1'b1;
          end else begin
            done = 1'b1;
            dlvl = lvl_i[0];
          end
        end else if (ok[0]) begin
          state_d   = FS_WAIT;
          arrived_d = 2'b01;
          lvl_d     = lvl_i[0];
        end else if (ok[1]) begin
          state_d   = FS_WAIT;
          arrived_d = 2'b10;
          lvl_d     = lvl_i[1];
        end
      end
      FS_WAIT: begin
        // Only the missing child can be accepted here.
        if (ok != 2'b00) begin
          cmp = ok[0] ? lvl_i[0] : lvl_i[1];
          if (cmp != lvl_q) begin
            err_o     = 1'b1;
            state_d   = FS_IDLE;
            arrived_d = 2'b00;
          end else begin
            done = 1'b1;
            dlvl = lvl_q;
          end
        end
      end
      FS_FWD: begin
        if (up_gnt_i) state_d = FS_UP_WAIT;
      end
      FS_UP_WAIT: begin
        if (up_rsp_i) begin
          state_d = FS_REL;
          pend_d  = 2'b11;
        end
      end
      FS_REL: begin
        pend_d = pend_q & ~rsp_hs_i;
        if (pend_d == 2'b00) begin
          state_d   = FS_IDLE;
          arrived_d = 2'b00;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    // A parent release is only expected while waiting for one.
    if (up_rsp_i && (state_q != FS_UP_WAIT)) err_o = 1'b1;

    if (done) begin
      arrived_d = 2'b11;
      lvl_d     = dlvl;
      if (dlvl == NODE_LVL_C) begin
        state_d = FS_REL;
        pend_d  = 2'b11;
      end else begin
        state_d = FS_FWD;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= FS_IDLE;
      arrived_q <= 2'b00;
      pend_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      pend_q    <= pend_d;
    end
  end

  // Stored barrier level; only observed while the entry is active.
  always_ff @(posedge clk_i) begin
    lvl_q <= lvl_d;
  end

  assign arrived_o = arrived_q;
  assign busy_o    = (state_q == FS_FWD) || (state_q == FS_UP_WAIT) || (state_q == FS_REL);
  assign fwd_o     = (state_q == FS_FWD);
  assign pend_o    = (state_q == FS_REL) ? pend_q : 2'b00;
  assign lvl_o     = lvl_q;

endmodule

// File: rtl/fsync_node.sv
// Fractal sync tree node: merges two children's barrier requests per ID,
// terminates or forwards them, and fans releases back down.
module fsync_node
  import magia_pkg::*;
#(
  parameter int unsigned LVL_W    = magia_pkg::TILE_FSYNC_W,
  parameter int unsigned NODE_LVL = 1,
  parameter int unsigned N_IDS    = magia_pkg::FSYNC_N_IDS,
  parameter int unsigned ID_W     = (N_IDS > 1) ? $clog2(N_IDS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            req_valid_i,
  input  logic [1:0][LVL_W-1:0] req_lvl_i,
  input  logic [1:0][ID_W-1:0]  req_id_i,
  output logic [1:0]            req_ready_o,
  output logic [1:0]            rsp_valid_o,
  output logic [1:0][ID_W-1:0]  rsp_id_o,
  input  logic [1:0]            rsp_ready_i,
  output logic                  up_req_valid_o,
  output logic [LVL_W-1:0]      up_req_lvl_o,
  output logic [ID_W-1:0]       up_req_id_o,
  input  logic                  up_req_ready_i,
  input  logic                  up_rsp_valid_i,
  input  logic [ID_W-1:0]       up_rsp_id_i,
  output logic                  up_rsp_ready_o,
  output logic                  error_o
);

  logic [N_IDS-1:0][1:0]       acc, hs, arrived, pend;
  logic [N_IDS-1:0]            busy, fwd, up_rsp, up_gnt, ent_err;
  logic [N_IDS-1:0][LVL_W-1:0] ent_lvl;

  logic            hold_q, hold_d;
  logic [ID_W-1:0] hold_idx_q, hold_idx_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic            err_q, err_d;
  logic [ID_W-1:0] sel, cand;
  logic            found;
  logic [1:0]      req_hit;

  for (genvar gi = 0; gi < N_IDS; gi++) begin : g_ent
    localparam logic [ID_W-1:0] ID = ID_W'(gi);

    assign acc[gi][0] = req_valid_i[0] & req_ready_o[0] & (req_id_i[0] == ID);
    assign acc[gi][1] = req_valid_i[1] & req_ready_o[1] & (req_id_i[1] == ID);
    assign hs[gi][0]  = rsp_valid_o[0] & rsp_ready_i[0] & (rsp_id_o[0] == ID);
    assign hs[gi][1]  = rsp_valid_o[1] & rsp_ready_i[1] & (rsp_id_o[1] == ID);
    assign up_rsp[gi] = up_rsp_valid_i & (up_rsp_id_i == ID);
    assign up_gnt[gi] = up_req_valid_o & up_req_ready_i & (sel == ID);

    fsync_id_entry #(
      .LVL_W    (LVL_W),
      .NODE_LVL (NODE_LVL)
    ) u_entry (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .acc_i     (acc[gi]),
      .lvl_i     (req_lvl_i),
      .up_gnt_i  (up_gnt[gi]),
      .up_rsp_i  (up_rsp[gi]),
      .rsp_hs_i  (hs[gi]),
      .arrived_o (arrived[gi]),
      .busy_o    (busy[gi]),
      .fwd_o     (fwd[gi]),
      .pend_o    (pend[gi]),
      .lvl_o     (ent_lvl[gi]),
      .err_o     (ent_err[gi])
    );
  end

  // Child request acceptance: blocked while the addressed ID already holds
  // this child's arrival or is past the pairing phase.
  always_comb begin
    req_ready_o = 2'b11;
    req_hit     = 2'b00;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < int'(N_IDS); i++) begin
        if (req_id_i[k] == ID_W'(i)) begin
          req_hit[k] = 1'b1;
          if (arrived[i][k] || busy[i]) req_ready_o[k] = 1'b0;
        end
      end
    end
  end

  // Release fan-out: each child port independently shows its lowest pending ID.
  always_comb begin
    rsp_valid_o = 2'b00;
    rsp_id_o    = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = int'(N_IDS) - 1; i >= 0; i--) begin
        if (pend[i][k]) begin
          rsp_valid_o[k] = 1'b1;
          rsp_id_o[k]    = ID_W'(i);
        end
      end
    end
  end

  // Round-robin up-port selection; a stalled winner stays locked so the
  // outgoing request is stable until the parent accepts it.
  always_comb begin
    sel   = hold_idx_q;
    found = hold_q;
    cand  = '0;
    if (!hold_q) begin
      for (int o = 0; o < int'(N_IDS); o++) begin
        cand = ID_W'((int'(rr_q) + o) % int'(N_IDS));
        if (!found && fwd[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  assign up_req_valid_o = found;
  assign up_req_id_o    = found ? sel : '0;
  assign up_req_lvl_o   = found ? ent_lvl[sel] : '0;
  assign up_rsp_ready_o = 1'b1;
  assign error_o        = err_q;

  // Arbiter bookkeeping and error collection for the next cycle.
  always_comb begin
    hold_d     = up_req_valid_o & ~up_req_ready_i;
    hold_idx_d = sel;
    rr_d       = rr_q;
    if (up_req_valid_o && up_req_ready_i) rr_d = ID_W'((int'(sel) + 1) % int'(N_IDS));
    // Unknown IDs (non-power-of-two N_IDS) are accepted and flagged.
    err_d = (|ent_err)
          | (up_rsp_valid_i & ~(|up_rsp))
          | (|(req_valid_i & req_ready_o & ~req_hit));
  end

  // Arbiter and error pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      rr_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      rr_q       <= rr_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fsync_node.sv
// Directed bench for fsync_node with NODE_LVL=1, four barrier IDs.
module tb_fsync_node;
  import magia_pkg::*;

  localparam int unsigned LW = TILE_FSYNC_W;
  localparam int unsigned NI = 4;
  localparam int unsigned IW = 2;

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic [1:0]         req_valid = 2'b00;
  logic [1:0][LW-1:0] req_lvl = '0;
  logic [1:0][IW-1:0] req_id = '0;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_valid;
  logic [1:0][IW-1:0] rsp_id;
  logic [1:0]         rsp_ready = 2'b11;
  logic               up_req_valid;
  logic [LW-1:0]      up_req_lvl;
  logic [IW-1:0]      up_req_id;
  logic               up_req_ready = 1'b0;
  logic               up_rsp_valid = 1'b0;
  logic [IW-1:0]      up_rsp_id = '0;
  logic               up_rsp_ready;
  logic               error;

  int total = 0;
  int bad   = 0;

  fsync_node #(
    .LVL_W    (LW),
    .NODE_LVL (1),
    .N_IDS    (NI),
    .ID_W     (IW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_lvl_i      (req_lvl),
    .req_id_i       (req_id),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_id_o       (rsp_id),
    .rsp_ready_i    (rsp_ready),
    .up_req_valid_o (up_req_valid),
    .up_req_lvl_o   (up_req_lvl),
    .up_req_id_o    (up_req_id),
    .up_req_ready_i (up_req_ready),
    .up_rsp_valid_i (up_rsp_valid),
    .up_rsp_id_i    (up_rsp_id),
    .up_rsp_ready_o (up_rsp_ready),
    .error_o        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input int lvl, input int id);
    req_valid[k] = v;
    req_lvl[k]   = LW'(lvl);
    req_id[k]    = IW'(id);
  endtask

  function automatic logic [31:0] up_vec();
    return 32'({up_req_valid, up_req_lvl, up_req_id});
  endfunction

  initial begin
    // Reset state
    tick; tick;
    chk("rst_req_ready", 32'(req_ready), 'h3);
    chk("rst_rsp_valid", 32'(rsp_valid), 'h0);
    chk("rst_rsp_id", 32'(rsp_id), 'h0);
    chk("rst_up_req", up_vec(), 'h0);
    chk("rst_error", 32'(error), 'h0);
    chk("rst_up_rsp_ready", 32'(up_rsp_ready), 'h1);
    rst_ni = 1'b1;
    tick;

    // Local barrier on id0: c0 at t0, c1 at t3
    set_req(0, 1'b1, 1, 0);
    #1 chk("loc_ready_c0", 32'(req_ready[0]), 'h1);
    tick;
    set_req(0, 1'b0, 1, 0);
    chk("loc_no_rsp_early", 32'(rsp_valid), 'h0);
    chk("loc_no_err", 32'(error), 'h0);
    tick; tick;
    set_req(1, 1'b1, 1, 0);
    tick;
    set_req(1, 1'b0, 1, 0);
    chk("loc_rsp_valid", 32'(rsp_valid), 'h3);
    chk("loc_rsp_id", 32'(rsp_id), 'h0);
    chk("loc_no_up", 32'(up_req_valid), 'h0);
    tick;
    chk("loc_released", 32'(rsp_valid), 'h0);

    // Forwarded barrier on id1 with a 5-cycle parent stall
    set_req(0, 1'b1, 2, 1);
    set_req(1, 1'b1, 2, 1);
    tick;
    set_req(0, 1'b0, 2, 1);
    set_req(1, 1'b0, 2, 1);
    chk("fwd_up_req", up_vec(), 'h29);
    chk("fwd_no_rsp", 32'(rsp_valid), 'h0);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("fwd_stall_stable", up_vec(), 'h29);
    end
    up_req_ready = 1'b1;
    tick;
    up_req_ready = 1'b0;
    chk("fwd_up_done", 32'(up_req_valid), 'h0);
    #1 chk("fwd_upwait_blocks", 32'(req_ready[0]), 'h0);
    up_rsp_valid = 1'b1;
    up_rsp_id    = 2'd1;
    tick;
    up_rsp_valid = 1'b0;
    chk("fwd_rsp_valid", 32'(rsp_valid), 'h3);
    chk("fwd_rsp_id", 32'(rsp_id), 'h5);
    chk("fwd_no_err", 32'(error), 'h0);
    tick;
    chk("fwd_released", 32'(rsp_valid), 'h0);

    // Concurrency: id0 (c0 first) and id2 (c1 first), round-robin up port
    set_req(0, 1'b1, 2, 0);
    tick;
    set_req(0, 1'b0, 2, 0);
    set_req(1, 1'b1, 2, 2);
    tick;
    set_req(0, 1'b1, 2, 2);
    set_req(1, 1'b1, 2, 0);
    #1 chk("conc_ready_both", 32'(req_ready), 'h3);
    tick;
    set_req(0, 1'b0, 2, 0);
    set_req(1, 1'b0, 2, 0);
    up_req_ready = 1'b1;
    chk("conc_first_grant", up_vec(), 'h2a);
    tick;
    chk("conc_second_grant", up_vec(), 'h28);
    tick;
    chk("conc_up_idle", 32'(up_req_valid), 'h0);
    up_req_ready = 1'b0;
    up_rsp_valid = 1'b1;
    up_rsp_id    = 2'd0;
    tick;
    up_rsp_valid = 1'b0;
    chk("conc_rel_id0_valid", 32'(rsp_valid), 'h3);
    chk("conc_rel_id0_id", 32'(rsp_id), 'h0);
    tick;
    up_rsp_valid = 1'b1;
    up_rsp_id    = 2'd2;
    tick;
    up_rsp_valid = 1'b0;
    chk("conc_rel_id2_valid", 32'(rsp_valid), 'h3);
    chk("conc_rel_id2_id", 32'(rsp_id), 'ha);
    tick;
    chk("conc_done", 32'(rsp_valid), 'h0);

    // Backpressure on requests and on releases
    set_req(0, 1'b1, 1, 0);
    tick;
    chk("bp_dup_blocked", 32'(req_ready[0]), 'h0);
    set_req(0, 1'b0, 1, 0);
    rsp_ready = 2'b01;
    set_req(1, 1'b1, 1, 0);
    tick;
    set_req(1, 1'b0, 1, 0);
    chk("bp_rel_both", 32'(rsp_valid), 'h3);
    tick;
    chk("bp_c1_pending", 32'(rsp_valid), 'h2);
    chk("bp_rel_blocks", 32'(req_ready[0]), 'h0);
    tick;
    chk("bp_c1_still", 32'(rsp_valid), 'h2);
    rsp_ready = 2'b11;
    tick;
    chk("bp_all_taken", 32'(rsp_valid), 'h0);
    chk("bp_id_free", 32'(req_ready), 'h3);

    // Errors: level mismatch, level below node, parent release for idle ID
    set_req(0, 1'b1, 1, 3);
    tick;
    set_req(0, 1'b0, 1, 3);
    set_req(1, 1'b1, 2, 3);
    tick;
    set_req(1, 1'b0, 2, 3);
    chk("err_lvl_mismatch", 32'(error), 'h1);
    chk("err_mismatch_no_rel", 32'(rsp_valid), 'h0);
    tick;
    chk("err_one_pulse", 32'(error), 'h0);
    chk("err_id3_idle", 32'(req_ready), 'h3);
    set_req(0, 1'b1, 0, 0);
    tick;
    set_req(0, 1'b0, 0, 0);
    chk("err_low_lvl", 32'(error), 'h1);
    tick;
    chk("err_low_lvl_unchanged", 32'(req_ready), 'h3);
    up_rsp_valid = 1'b1;
    up_rsp_id    = 2'd2;
    tick;
    up_rsp_valid = 1'b0;
    chk("err_idle_uprsp", 32'(error), 'h1);
    tick;
    chk("err_idle_uprsp_end", 32'(error), 'h0);

    // Reset while id1 is waiting on the parent
    set_req(0, 1'b1, 2, 1);
    set_req(1, 1'b1, 2, 1);
    tick;
    set_req(0, 1'b0, 2, 1);
    set_req(1, 1'b0, 2, 1);
    up_req_ready = 1'b1;
    chk("rst2_fwd", up_vec(), 'h29);
    tick;
    up_req_ready = 1'b0;
    #1 chk("rst2_upwait", 32'(req_ready), 'h0);
    rst_ni = 1'b0;
    tick;
    chk("rst2_ready", 32'(req_ready), 'h3);
    chk("rst2_rsp", 32'(rsp_valid), 'h0);
    chk("rst2_up", up_vec(), 'h0);
    chk("rst2_err", 32'(error), 'h0);
    rst_ni = 1'b1;
    up_rsp_valid = 1'b1;
    up_rsp_id    = 2'd1;
    tick;
    up_rsp_valid = 1'b0;
    chk("rst2_stale_rsp_err", 32'(error), 'h1);
    chk("rst2_stale_no_rel", 32'(rsp_valid), 'h0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
